// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback slice.
package rf_pkg;

    localparam int DW    = 32;
    localparam int ADDRW = 5;
    localparam int NREGS = 32;

    typedef logic [ADDRW-1:0] reg_addr_t;

    // Identifies which writeback source was granted most recently.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRW = rf_pkg::ADDRW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_en_i,
    input  logic [ADDRW-1:0] issue_rd_i,
    input  logic             wr_en_i,
    input  logic [ADDRW-1:0] wr_addr_i,
    input  logic [ADDRW-1:0] rs1_i,
    input  logic [ADDRW-1:0] rs2_i,
    output logic             hazard_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: clear on writeback first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (issue_en_i && (issue_rd_i != {ADDRW{1'b0}})) begin
            busy_d[issue_rd_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin ALU/LSU writeback arbiter driving one register-file write port.
// Optional pending-write scoreboard enabled by macro RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DW    = rf_pkg::DW,
    parameter int ADDRW = rf_pkg::ADDRW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid_i,
    input  logic [ADDRW-1:0] alu_rd_i,
    input  logic [DW-1:0]    alu_data_i,
    output logic             alu_ready_o,
    input  logic             lsu_valid_i,
    input  logic [ADDRW-1:0] lsu_rd_i,
    input  logic [DW-1:0]    lsu_data_i,
    output logic             lsu_ready_o,
    output logic             wr_en_o,
    output logic [ADDRW-1:0] wr_addr_o,
    output logic [DW-1:0]    wr_data_o,
    input  logic             issue_en_i,
    input  logic [ADDRW-1:0] issue_rd_i,
    input  logic [ADDRW-1:0] rs1_i,
    input  logic [ADDRW-1:0] rs2_i,
    output logic             hazard_o
);

    wb_src_e          last_q;
    wb_src_e          last_d;
    logic             alu_gnt_s;
    logic             lsu_gnt_s;
    logic             xfer_s;
    logic [ADDRW-1:0] sel_rd_s;
    logic [DW-1:0]    sel_data_s;
    logic             wr_en_q;
    logic [ADDRW-1:0] wr_addr_q;
    logic [DW-1:0]    wr_data_q;

    // Grant selection: lone requester wins, ties go to the source not granted last.
    always_comb begin
        alu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
        if (rst) begin
            alu_gnt_s = alu_valid_i & (~lsu_valid_i | (last_q == WB_LSU));
            lsu_gnt_s = lsu_valid_i & (~alu_valid_i | (last_q == WB_ALU));
        end else begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end
    end

    assign xfer_s      = alu_gnt_s | lsu_gnt_s;
    assign sel_rd_s    = alu_gnt_s ? alu_rd_i   : lsu_rd_i;
    assign sel_data_s  = alu_gnt_s ? alu_data_i : lsu_data_i;
    assign alu_ready_o = alu_gnt_s;
    assign lsu_ready_o = lsu_gnt_s;

    // Pointer next state: moves only when a transfer happens.
    always_comb begin
        last_d = last_q;
        if (alu_gnt_s) begin
            last_d = WB_ALU;
        end else if (lsu_gnt_s) begin
            last_d = WB_LSU;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset value lets the ALU win the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= WB_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    // Write-port stage: one-cycle latency, x0 writes accepted but never enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDRW{1'b0}};
            wr_data_q <= {DW{1'b0}};
        end else if (xfer_s) begin
            wr_en_q   <= (sel_rd_s != {ADDRW{1'b0}});
            wr_addr_q <= sel_rd_s;
            wr_data_q <= sel_data_s;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    // Gating with rst drops a write that was accepted just before reset asserts.
    assign wr_en_o   = wr_en_q & rst;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

`ifdef RF_WB_SCOREBOARD_EN
    rf_scoreboard #(
        .ADDRW (ADDRW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en_i (issue_en_i),
        .issue_rd_i (issue_rd_i),
        .wr_en_i    (wr_en_o),
        .wr_addr_i  (wr_addr_o),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .hazard_o   (hazard_o)
    );
`else
    logic unused_issue_s;
    assign unused_issue_s = ^{issue_en_i, issue_rd_i, rs1_i, rs2_i};
    assign hazard_o       = 1'b0;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDRW, default 5, meaning register address width (32 registers).
REQ-003 The block SHALL have port clk, input, 1, clock; all state rises on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have ports alu_valid_i (input, 1), alu_rd_i (input, ADDRW) and alu_data_i (input, DW), meaning the ALU writeback request.
REQ-006 The block SHALL have port alu_ready_o, output, 1, meaning the ALU request is granted this cycle.
REQ-007 The block SHALL have ports lsu_valid_i (input, 1), lsu_rd_i (input, ADDRW) and lsu_data_i (input, DW), meaning the load-unit writeback request.
REQ-008 The block SHALL have port lsu_ready_o, output, 1, meaning the LSU request is granted this cycle.
REQ-009 The block SHALL have ports wr_en_o (output, 1), wr_addr_o (output, ADDRW) and wr_data_o (output, DW), which drive the register-file write port.
REQ-010 The block SHALL have ports issue_en_i (input, 1) and issue_rd_i (input, ADDRW), meaning an instruction is issued that targets rd.
REQ-011 The block SHALL have ports rs1_i and rs2_i, input, ADDRW each, meaning the source registers of the instruction in decode.
REQ-012 The block SHALL have port hazard_o, output, 1, meaning a source register has a pending write; the output is combinational.

Function
REQ-013 A transfer SHALL occur on a source when its valid and ready are both high at posedge clk.
REQ-014 Ready SHALL be combinational from the valids and the last-grant pointer; at most one ready is high per cycle.
REQ-015 If exactly one source is valid, that source SHALL be granted.
REQ-016 If both sources are valid, the source not granted last SHALL be granted (round-robin); the pointer updates only on a transfer.
REQ-017 The requester SHALL hold valid, rd and data stable until it is granted; the block does not check this.
REQ-018 A granted request SHALL appear on wr_en_o, wr_addr_o and wr_data_o exactly 1 cycle later (registered); wr_en_o is high for one cycle per transfer.
REQ-019 A transfer with rd=0 SHALL be accepted, but wr_en_o SHALL stay 0 for it.
REQ-020 With no transfer, wr_en_o SHALL be 0 and wr_addr_o/wr_data_o SHALL hold their previous values.
REQ-021 Back-to-back transfers SHALL sustain 1 write per cycle with no bubble.

Reset
REQ-022 When rst=0 at posedge clk, the outputs SHALL reset as follows: wr_en_o=0, wr_addr_o=0, wr_data_o=0, and the last-grant pointer set so the ALU wins the first tie.
REQ-023 During reset, alu_ready_o and lsu_ready_o SHALL be 0.
REQ-024 A transfer accepted in the cycle before reset SHALL be discarded and never written.

Configuration
REQ-025 The block SHALL compile a scoreboard when macro RF_WB_SCOREBOARD_EN is defined, consisting of a 32-bit busy vector.
REQ-026 With RF_WB_SCOREBOARD_EN: issue_en_i with issue_rd_i≠0 SHALL set busy[issue_rd_i], and a write on wr_en_o SHALL clear busy[wr_addr_o].
REQ-027 With RF_WB_SCOREBOARD_EN, if a set and a clear hit the same register in one cycle, the set SHALL win; busy[0] SHALL always be 0; reset SHALL clear all busy bits.
REQ-028 With RF_WB_SCOREBOARD_EN, hazard_o SHALL equal busy[rs1_i] | busy[rs2_i] (current state, no same-cycle bypass).
REQ-029 Without RF_WB_SCOREBOARD_EN, hazard_o SHALL be tied 0, issue_en_i, issue_rd_i, rs1_i and rs2_i SHALL be ignored, and no busy flops SHALL exist.

Structure
REQ-030 Package rf_pkg SHALL hold constants DW, ADDRW and NREGS=32, typedef reg_addr_t, and enum wb_src_e {WB_ALU, WB_LSU} for the pointer.
REQ-031 The scoreboard SHALL be the sub-module rf_scoreboard, instantiated only under RF_WB_SCOREBOARD_EN; the arbiter and output stage SHALL stay inline.

Verification
REQ-032 The bench SHALL cover: after reset, ALU only (rd=3, data=0xA5A5A5A5) -> alu_ready_o=1, and next cycle wr_en_o=1, wr_addr_o=3, wr_data_o=0xA5A5A5A5.
REQ-033 The bench SHALL cover: both valid for 4 cycles (ALU rd=1, LSU rd=2) -> grants ALU, LSU, ALU, LSU, and writes to 1, 2, 1, 2 on consecutive cycles.
REQ-034 The bench SHALL cover: LSU rd=0, data=0xFFFFFFFF -> lsu_ready_o=1, and next cycle wr_en_o=0.
REQ-035 The bench SHALL cover: grant ALU rd=7, then assert rst=0 in the following cycle -> wr_en_o=0, and no write to register 7 ever appears.
REQ-036 The bench SHALL cover (with RF_WB_SCOREBOARD_EN): issue rd=5, rs1=5 -> hazard_o=1 next cycle; after the write to 5 -> hazard_o=0; re-issue of rd=5 in the same cycle as the write to 5 -> busy[5] stays 1.
